// File: rtl/resource_arbiter_if.sv
// Bundle between the shared adder/comparator arbiter and its clients/shared units.
// Client k occupies bits [k*N +: N] of every flattened per-client operand bus.
interface resource_arbiter_if #(
    parameter int N = 8,
    parameter int M = 2
);
    logic [M-1:0]   i_request;
    logic [M-1:0]   o_start;
    logic [M-1:0]   i_finished;
    logic [M-1:0]   o_grant;
    logic           o_busy;

    logic [M*N-1:0] i_client_augend;
    logic [M*N-1:0] i_client_addend;
    logic [N-1:0]   o_client_sum;
    logic [M*N-1:0] i_client_left;
    logic [M*N-1:0] i_client_right;
    logic [M-1:0]   o_client_equal;

    logic [N-1:0]   o_adder_augend;
    logic [N-1:0]   o_adder_addend;
    logic [N-1:0]   i_adder_sum;
    logic [N-1:0]   o_comparator_left;
    logic [N-1:0]   o_comparator_right;
    logic           i_comparator_equal;

    modport slave (
        input  i_request, i_finished,
        input  i_client_augend, i_client_addend, i_client_left, i_client_right,
        input  i_adder_sum, i_comparator_equal,
        output o_start, o_grant, o_busy, o_client_sum, o_client_equal,
        output o_adder_augend, o_adder_addend, o_comparator_left, o_comparator_right
    );

    modport master (
        output i_request, i_finished,
        output i_client_augend, i_client_addend, i_client_left, i_client_right,
        output i_adder_sum, i_comparator_equal,
        input  o_start, o_grant, o_busy, o_client_sum, o_client_equal,
        input  o_adder_augend, o_adder_addend, o_comparator_left, o_comparator_right
    );
endinterface

// File: rtl/resource_arbiter.sv
// Round-robin owner of the shared adder and equality comparator; a client keeps
// both units for a whole operation, from its start pulse until it reports finished.
//
// state | meaning
// IDLE  | no owner; shared operands forced to zero; waiting for a request
// START | owner g latched; one-cycle start pulse to g; g may finish immediately
// BUSY  | owner g iterating; leaves on i_finished[g] only
module resource_arbiter #(
    parameter int N = 8,
    parameter int M = 2
) (
    input  logic               i_clock,
    input  logic               i_reset,
    resource_arbiter_if.slave  bus
);
    localparam int GW = $clog2(M);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t         state;
    logic [GW-1:0]  g;
    logic [GW-1:0]  p;
    logic [M-1:0]   start_q;
    logic [M-1:0]   grant_q;
    logic           busy_q;

    logic [GW-1:0]  pick;
    logic           found;
    logic [GW-1:0]  next_p;

    // Walk downward so the candidate closest to the pointer is the last one written.
    always_comb begin
        int idx;
        idx   = 0;
        pick  = p;
        found = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % M;
            if (bus.i_request[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
    end

    assign next_p = (g == GW'(M - 1)) ? '0 : g + 1'b1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= IDLE;
            g       <= '0;
            p       <= '0;
            start_q <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= START;
                        g       <= pick;
                        start_q <= M'(1) << pick;
                        grant_q <= M'(1) << pick;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    start_q <= '0;
                    if (bus.i_finished[g]) begin
                        state   <= IDLE;
                        p       <= next_p;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end else begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.i_finished[g]) begin
                        state   <= IDLE;
                        p       <= next_p;
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    start_q <= '0;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_start        = start_q;
    assign bus.o_grant        = grant_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_client_sum   = bus.i_adder_sum;
    // Non-owners never see equal, so clients deriving finished from it stay quiet.
    assign bus.o_client_equal = {M{bus.i_comparator_equal}} & grant_q;

    always_comb begin
        bus.o_adder_augend     = '0;
        bus.o_adder_addend     = '0;
        bus.o_comparator_left  = '0;
        bus.o_comparator_right = '0;
        if (busy_q) begin
            bus.o_adder_augend     = bus.i_client_augend[int'(g) * N +: N];
            bus.o_adder_addend     = bus.i_client_addend[int'(g) * N +: N];
            bus.o_comparator_left  = bus.i_client_left[int'(g) * N +: N];
            bus.o_comparator_right = bus.i_client_right[int'(g) * N +: N];
        end
    end
endmodule

// File: tb/tb_resource_arbiter.sv
// Directed bench for resource_arbiter: grant timing, round-robin, zero-length ops,
// foreign finish, operand steering and reset mid-operation.
module tb_resource_arbiter;
    localparam int N = 8;
    localparam int M = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    resource_arbiter_if #(.N(N), .M(M)) bus ();

    resource_arbiter #(.N(N), .M(M)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst                    = 1'b1;
        bus.i_request          = '0;
        bus.i_finished         = '0;
        bus.i_client_augend    = {8'h5A, 8'h11};
        bus.i_client_addend    = {8'h6B, 8'h22};
        bus.i_client_left      = {8'h33, 8'h44};
        bus.i_client_right     = {8'h7C, 8'h55};
        bus.i_adder_sum        = 8'hA5;
        bus.i_comparator_equal = 1'b1;
        tick;
        tick;

        check_val("rst_start", 32'(bus.o_start), 32'h0);
        check_val("rst_grant", 32'(bus.o_grant), 32'h0);
        check_val("rst_busy",  32'(bus.o_busy),  32'h0);
        check_val("rst_equal", 32'(bus.o_client_equal), 32'h0);
        check_val("rst_sum",   32'(bus.o_client_sum), 32'hA5);
        check_val("rst_augend", 32'(bus.o_adder_augend), 32'h0);
        check_val("rst_left",  32'(bus.o_comparator_left), 32'h0);

        // Client 0 alone, three iterations: grant held START + 3 cycles.
        rst = 1'b0;
        bus.i_comparator_equal = 1'b0;
        bus.i_request = 2'b01;
        tick;
        check_val("c0_start",  32'(bus.o_start), 32'h1);
        check_val("c0_grant",  32'(bus.o_grant), 32'h1);
        check_val("c0_busy",   32'(bus.o_busy),  32'h1);
        check_val("c0_augend", 32'(bus.o_adder_augend), 32'h11);
        check_val("c0_right",  32'(bus.o_comparator_right), 32'h55);
        bus.i_request = 2'b00;
        tick;
        check_val("c0_it1_start", 32'(bus.o_start), 32'h0);
        check_val("c0_it1_grant", 32'(bus.o_grant), 32'h1);
        bus.i_finished = 2'b10;
        tick;
        check_val("c0_foreign_fin", 32'(bus.o_grant), 32'h1);
        bus.i_finished = 2'b00;
        tick;
        check_val("c0_it3_grant", 32'(bus.o_grant), 32'h1);
        bus.i_comparator_equal = 1'b1;
        #1;
        check_val("c0_equal", 32'(bus.o_client_equal), 32'h1);
        bus.i_finished = 2'b01;
        tick;
        bus.i_finished = 2'b00;
        bus.i_comparator_equal = 1'b0;
        check_val("c0_done_grant", 32'(bus.o_grant), 32'h0);
        check_val("c0_done_busy",  32'(bus.o_busy),  32'h0);
        check_val("idle_augend",   32'(bus.o_adder_augend), 32'h0);
        check_val("idle_left",     32'(bus.o_comparator_left), 32'h0);

        // Client 1 owner: steering of all four operands and owner-only equal.
        bus.i_request = 2'b10;
        tick;
        check_val("c1_start",  32'(bus.o_start), 32'h2);
        check_val("c1_grant",  32'(bus.o_grant), 32'h2);
        check_val("c1_augend", 32'(bus.o_adder_augend), 32'h5A);
        check_val("c1_addend", 32'(bus.o_adder_addend), 32'h6B);
        check_val("c1_left",   32'(bus.o_comparator_left), 32'h33);
        check_val("c1_right",  32'(bus.o_comparator_right), 32'h7C);
        bus.i_comparator_equal = 1'b1;
        bus.i_adder_sum = 8'h3C;
        #1;
        check_val("c1_equal", 32'(bus.o_client_equal), 32'h2);
        check_val("c1_sum",   32'(bus.o_client_sum), 32'h3C);
        bus.i_comparator_equal = 1'b0;
        bus.i_request = 2'b11;
        tick;
        check_val("c1_busy_grant", 32'(bus.o_grant), 32'h2);

        // Reset mid-BUSY with owner 1; pointer returns to client 0.
        rst = 1'b1;
        bus.i_comparator_equal = 1'b1;
        tick;
        check_val("mid_rst_start",  32'(bus.o_start), 32'h0);
        check_val("mid_rst_grant",  32'(bus.o_grant), 32'h0);
        check_val("mid_rst_busy",   32'(bus.o_busy),  32'h0);
        check_val("mid_rst_equal",  32'(bus.o_client_equal), 32'h0);
        check_val("mid_rst_augend", 32'(bus.o_adder_augend), 32'h0);
        rst = 1'b0;
        bus.i_comparator_equal = 1'b0;
        tick;
        check_val("post_rst_grant", 32'(bus.o_grant), 32'h1);
        check_val("post_rst_start", 32'(bus.o_start), 32'h1);

        // Both requesting: zero-length ops alternate with one idle cycle between.
        bus.i_finished = 2'b01;
        tick;
        bus.i_finished = 2'b00;
        check_val("rr_gap0", 32'(bus.o_grant), 32'h0);
        tick;
        check_val("rr_grant1", 32'(bus.o_grant), 32'h2);
        check_val("rr_start1", 32'(bus.o_start), 32'h2);
        bus.i_finished = 2'b10;
        tick;
        bus.i_finished = 2'b00;
        check_val("zero_len_grant", 32'(bus.o_grant), 32'h0);
        check_val("zero_len_busy",  32'(bus.o_busy),  32'h0);
        tick;
        check_val("rr_grant0", 32'(bus.o_grant), 32'h1);
        bus.i_finished = 2'b01;
        tick;
        bus.i_finished = 2'b00;
        check_val("rr_gap1", 32'(bus.o_grant), 32'h0);
        tick;
        check_val("rr_grant1b", 32'(bus.o_grant), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/resource_arbiter.md
# resource_arbiter

Shares the single adder and single equality comparator among M iterative datapath clients, such as the shifter and future multiplier/divider sequencers. Each client borrows both resources for a whole operation. The arbiter grants one client at a time in round-robin order, issues that client's start pulse, and steers its operands to the shared units. It routes results back only to the owner and releases ownership when the owner reports finished.

## Interface
- N, 8, operand width (matches client/adder/comparator width)
- M, 2, number of clients (2..4); client k occupies bits [k*N +: N] of each flattened bus
- i_clock  in  1  system clock; all state on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_request  in  M  client k wants the shared resources; level, held until o_start[k]
- o_start  out  M  one-cycle start pulse to the granted client (drives the client's i_start)
- i_finished  in  M  client k's finished flag; sampled only from the owner
- o_grant  out  M  one-hot ownership; all-zero when idle
- o_busy  out  1  an operation is in progress (state START or BUSY)
- i_client_augend / i_client_addend  in  M*N  per-client adder operands
- o_client_sum  out  N  i_adder_sum broadcast to all clients
- i_client_left / i_client_right  in  M*N  per-client comparator operands
- o_client_equal  out  M  i_comparator_equal gated to the owner only
- o_adder_augend / o_adder_addend  out  N  to shared adder
- i_adder_sum  in  N  from shared adder
- o_comparator_left / o_comparator_right  out  N  to shared comparator
- i_comparator_equal  in  1  from shared comparator

## Operation
- Registered state: state ∈ {IDLE, START, BUSY}, owner index g (log2 M bits), priority pointer p.
- Reset: state=IDLE, g=0, p=0. Reset applies from any state, including mid-operation. The owner's operation is abandoned and no start or finish is reported.
- IDLE:
  - If any i_request bit is set, select the first set bit searching p, p+1, … mod M, latch it into g, and go to START.
  - Otherwise stay in IDLE.
- START:
  - o_start[g]=1 for this cycle only.
  - If i_finished[g]=1 in the same cycle (zero-iteration client), set p=(g+1) mod M and go to IDLE.
  - Otherwise go to BUSY.
- BUSY: on i_finished[g]=1, set p=(g+1) mod M and go to IDLE. Otherwise stay in BUSY.
- Steering (combinational):
  - In START/BUSY, the adder and comparator ports carry client g's operand slices.
  - In IDLE, all four shared-operand outputs are 0.
- o_grant[k] = (state≠IDLE) & (g==k). o_busy = (state≠IDLE).
- o_client_equal[k] = i_comparator_equal & o_grant[k]. Non-owners always see 0, which prevents spurious finishes in clients that derive finished from equal.
- o_client_sum = i_adder_sum unconditionally. Non-owners must ignore it.
- Ownership changes only via finished or reset:
  - Dropping i_request after grant has no effect.
  - i_finished from non-owners is ignored.
  - Requests arriving during BUSY wait.
- Pure routing/arbitration: no arithmetic; widths pass through unchanged.

## Timing
- Reset values: o_start=0, o_grant=0, o_busy=0, o_client_equal=0, o_client_sum=i_adder_sum, shared-operand outputs=0.
- Request high in IDLE at cycle t → o_start[g] and o_grant[g] high at t+1. Operands are routed from t+1.
- Owner finished at cycle f → o_grant=0 and state=IDLE at f+1. The next grant's o_start is earliest at f+2 (one idle cycle between operations).
- Minimum occupancy: 1 cycle (finish during START). Operation occupancy equals client iterations + 1 cycles including the START cycle.
- Simultaneous requests in IDLE resolve by the pointer only; there is no fixed priority.

## Test plan
- Single client, M=2, N=8: client 0 requests, shifter with i_iterations=3 → o_start[0] at t+1, o_grant=2'b01 for 4 cycles, o_client_equal[0] pulses once, IDLE at the following cycle, o_client_equal[1] never high.
- Round-robin: both request continuously from reset → grants alternate 0,1,0,1; each o_start is preceded by ≥1 idle cycle after the previous finish.
- Zero-length op: client 1 granted with i_finished[1] high in the START cycle → o_grant=0 next cycle, p=0.
- Request drop and foreign finish: client 0 drops its request after grant, and client 1 asserts i_finished mid-op → grant held until i_finished[0].
- Steering: owner 1 drives augend=0x5A and left=0x33 → o_adder_augend=0x5A and o_comparator_left=0x33; in IDLE both are 0x00.
- Reset mid-BUSY: assert i_reset with owner 1 → next cycle all outputs at reset values; with both requesting, the next grant goes to client 0.
